// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the MBIST controller.
package mbist_pkg;

   typedef enum logic [2:0] {
      ElemM0,
      ElemM1,
      ElemM2,
      ElemM3,
      ElemM4,
      ElemM5
   } march_elem_e;

   typedef enum logic {
      OpRd,
      OpWr
   } op_e;

   typedef logic [1:0] fsm_e;
   localparam fsm_e StIdle  = 2'd0;
   localparam fsm_e StRun   = 2'd1;
   localparam fsm_e StDrain = 2'd2;
   localparam fsm_e StDone  = 2'd3;

   // Per-element attributes: address direction, one or two ops per address,
   // op kind of a single-op element, and the read/write background bits.
   typedef struct packed {
      logic down;
      logic two_ops;
      op_e  first_op;
      logic rd_bg;
      logic wr_bg;
   } elem_cfg_t;

   function automatic elem_cfg_t elem_cfg(input march_elem_e e);
      elem_cfg_t c;
      c = '{down: 1'b0, two_ops: 1'b0, first_op: OpRd, rd_bg: 1'b0, wr_bg: 1'b0};
      case (e)
         ElemM0: c = '{down: 1'b0, two_ops: 1'b0, first_op: OpWr, rd_bg: 1'b0, wr_bg: 1'b0};
         ElemM1: c = '{down: 1'b0, two_ops: 1'b1, first_op: OpRd, rd_bg: 1'b0, wr_bg: 1'b1};
         ElemM2: c = '{down: 1'b0, two_ops: 1'b1, first_op: OpRd, rd_bg: 1'b1, wr_bg: 1'b0};
         ElemM3: c = '{down: 1'b1, two_ops: 1'b1, first_op: OpRd, rd_bg: 1'b0, wr_bg: 1'b1};
         ElemM4: c = '{down: 1'b1, two_ops: 1'b1, first_op: OpRd, rd_bg: 1'b1, wr_bg: 1'b0};
         ElemM5: c = '{down: 1'b0, two_ops: 1'b0, first_op: OpRd, rd_bg: 1'b0, wr_bg: 1'b0};
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Linear up/down address counter for March elements.
module mbist_addr_gen #(
   parameter int unsigned AddrBits = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load_i,       // start of element: load 0 or N-1
   input  logic                load_down_i,  // direction of the element being loaded
   input  logic                step_i,
   input  logic                down_i,       // direction of the current element
   output logic [AddrBits-1:0] addr_o,
   output logic                last_o
);

   logic [AddrBits-1:0] addr_q, addr_d;

   // Next address: load has priority over stepping.
   always_comb begin
      addr_d = addr_q;
      if (load_i) begin
         addr_d = load_down_i ? {AddrBits{1'b1}} : {AddrBits{1'b0}};
      end else if (step_i) begin
         addr_d = down_i ? addr_q - AddrBits'(1) : addr_q + AddrBits'(1);
      end
   end

   // Address register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign addr_o = addr_q;
   assign last_o = down_i ? (addr_q == {AddrBits{1'b0}}) : (addr_q == {AddrBits{1'b1}});

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: sequences ops, compares reads, logs failures.
module mbist_march_ctrl
   import mbist_pkg::*;
#(
   parameter int unsigned ROW_ADDR_BITS = 4,
   parameter int unsigned COL_ADDR_BITS = 4,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned FAIL_CNT_BITS = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     wr_en,
   output logic                     rd_en,
   output logic [ROW_ADDR_BITS-1:0] row_addr,
   output logic [COL_ADDR_BITS-1:0] col_addr,
   output logic [DATA_WIDTH-1:0]    data_out,
   input  logic [DATA_WIDTH-1:0]    data_in,
   output logic                     busy,
   output logic                     done,
   output logic                     fail,
   output logic                     fail_valid,
   output logic [ROW_ADDR_BITS-1:0] fail_row,
   output logic [COL_ADDR_BITS-1:0] fail_col,
   output logic [DATA_WIDTH-1:0]    fail_syndrome,
   output logic [FAIL_CNT_BITS-1:0] fail_count
);

   localparam int unsigned AddrBits = ROW_ADDR_BITS + COL_ADDR_BITS;

   fsm_e        state_q, state_d;
   march_elem_e elem_q, elem_d;
   logic        phase_q, phase_d;  // 0: read (or sole op), 1: write of a two-op element
   elem_cfg_t   cfg, next_cfg;
   op_e         cur_op;

   logic [AddrBits-1:0] addr;
   logic                addr_last;
   logic                ag_load, ag_load_down, ag_step;
   logic                clear_log;
   logic                run, elem_op_last;

   logic                  exp_valid_q, exp_valid_d;
   logic [DATA_WIDTH-1:0] exp_data_q, exp_data_d;
   logic [AddrBits-1:0]   exp_addr_q, exp_addr_d;

   logic                     fail_q, fail_d;
   logic [FAIL_CNT_BITS-1:0] fail_count_q, fail_count_d;
   logic [AddrBits-1:0]      ff_addr_q, ff_addr_d;
   logic [DATA_WIDTH-1:0]    ff_syn_q, ff_syn_d;

   logic                  mismatch;
   logic [DATA_WIDTH-1:0] syndrome;

   assign cfg          = elem_cfg(elem_q);
   assign next_cfg     = elem_cfg(march_elem_e'(elem_q + 3'd1));
   assign cur_op       = cfg.two_ops ? (phase_q ? OpWr : OpRd) : cfg.first_op;
   assign run          = (state_q == StRun);
   assign elem_op_last = !cfg.two_ops || phase_q;

   mbist_addr_gen #(
      .AddrBits (AddrBits)
   ) u_addr_gen (
      .clk_i       (clk),
      .rst_i       (rst),
      .load_i      (ag_load),
      .load_down_i (ag_load_down),
      .step_i      (ag_step),
      .down_i      (cfg.down),
      .addr_o      (addr),
      .last_o      (addr_last)
   );

   // Sequencer: element/phase/address advance and top-level state transitions.
   always_comb begin
      state_d      = state_q;
      elem_d       = elem_q;
      phase_d      = phase_q;
      ag_load      = 1'b0;
      ag_load_down = 1'b0;
      ag_step      = 1'b0;
      clear_log    = 1'b0;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d   = StRun;
               elem_d    = ElemM0;
               phase_d   = 1'b0;
               ag_load   = 1'b1;
               clear_log = 1'b1;
            end
         end
         StRun: begin
            if (!elem_op_last) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (!addr_last) begin
                  ag_step = 1'b1;
               end else if (elem_q == ElemM5) begin
                  state_d = StDrain;
               end else begin
                  elem_d       = march_elem_e'(elem_q + 3'd1);
                  ag_load      = 1'b1;
                  ag_load_down = next_cfg.down;
               end
            end
         end
         StDrain: state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   // Sequencer state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         elem_q  <= ElemM0;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         phase_q <= phase_d;
      end
   end

   // Memory-side strobes; address and data are forced to 0 when idle.
   always_comb begin
      wr_en                = run && (cur_op == OpWr);
      rd_en                = run && (cur_op == OpRd);
      {row_addr, col_addr} = run ? addr : '0;
      data_out             = (wr_en && cfg.wr_bg) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
      busy                 = (state_q == StRun) || (state_q == StDrain);
      done                 = (state_q == StDone);
   end

   // Capture expected data and address alongside each read for next-cycle compare.
   always_comb begin
      exp_valid_d = rd_en;
      exp_data_d  = {DATA_WIDTH{cfg.rd_bg}};
      exp_addr_d  = addr;
   end

   // Compare pipeline registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_valid_q <= 1'b0;
         exp_data_q  <= '0;
         exp_addr_q  <= '0;
      end else begin
         exp_valid_q <= exp_valid_d;
         exp_data_q  <= exp_data_d;
         exp_addr_q  <= exp_addr_d;
      end
   end

   assign syndrome = data_in ^ exp_data_q;
   assign mismatch = exp_valid_q && (syndrome != '0);

   // Failure log: sticky flag, saturating count, first-fail record.
   always_comb begin
      fail_d       = fail_q;
      fail_count_d = fail_count_q;
      ff_addr_d    = ff_addr_q;
      ff_syn_d     = ff_syn_q;
      if (clear_log) begin
         fail_d       = 1'b0;
         fail_count_d = '0;
         ff_addr_d    = '0;
         ff_syn_d     = '0;
      end else if (mismatch) begin
         fail_d = 1'b1;
         if (fail_count_q != {FAIL_CNT_BITS{1'b1}}) begin
            fail_count_d = fail_count_q + FAIL_CNT_BITS'(1);
         end
         if (!fail_q) begin
            ff_addr_d = exp_addr_q;
            ff_syn_d  = syndrome;
         end
      end
   end

   // Failure log registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_q       <= 1'b0;
         fail_count_q <= '0;
         ff_addr_q    <= '0;
         ff_syn_q     <= '0;
      end else begin
         fail_q       <= fail_d;
         fail_count_q <= fail_count_d;
         ff_addr_q    <= ff_addr_d;
         ff_syn_q     <= ff_syn_d;
      end
   end

   // Live failure on a fail_valid cycle, otherwise the first-fail record.
   always_comb begin
      fail_valid           = mismatch;
      fail                 = fail_q;
      fail_count           = fail_count_q;
      {fail_row, fail_col} = mismatch ? exp_addr_q : ff_addr_q;
      fail_syndrome        = mismatch ? syndrome : ff_syn_q;
   end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl with a behavioural memory and fault models.
module tb_mbist_march_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic start, start2;

   logic       wr_en, rd_en, busy, done, fail, fail_valid;
   logic [3:0] row_addr, col_addr, fail_row, fail_col;
   logic [7:0] data_out, fail_syndrome, fail_count;
   logic [7:0] data_in = 8'h00;

   logic       wr_en2, rd_en2, busy2, done2, fail2, fail_valid2;
   logic [3:0] row_addr2, col_addr2, fail_row2, fail_col2;
   logic [7:0] data_out2, fail_syndrome2;
   logic [1:0] fail_count2;
   logic [7:0] data_in2 = 8'h00;

   logic [7:0] mem  [256];
   logic [7:0] mem2 [256];

   logic saf0_en = 1'b0;  // bit 0 stuck-at-0 at (3,2)
   logic saf1_en = 1'b0;  // bit 7 stuck-at-1 on row 5
   logic cpl_en  = 1'b0;  // w1 to (2,3) flips bit 0 of (3,4)

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int cyc_done;

   logic mon_clr = 1'b0;
   logic mon_en  = 1'b0;
   int   ops, both_hi, pulses;
   int   fv_cyc [2];
   logic [3:0] fv_row, fv_col;
   logic [7:0] fv_syn;

   always #5 clk = ~clk;

   mbist_march_ctrl #(
      .ROW_ADDR_BITS (4), .COL_ADDR_BITS (4), .DATA_WIDTH (8), .FAIL_CNT_BITS (8)
   ) dut (
      .clk (clk), .rst (rst), .start (start), .wr_en (wr_en), .rd_en (rd_en),
      .row_addr (row_addr), .col_addr (col_addr), .data_out (data_out), .data_in (data_in),
      .busy (busy), .done (done), .fail (fail), .fail_valid (fail_valid),
      .fail_row (fail_row), .fail_col (fail_col), .fail_syndrome (fail_syndrome),
      .fail_count (fail_count)
   );

   mbist_march_ctrl #(
      .ROW_ADDR_BITS (4), .COL_ADDR_BITS (4), .DATA_WIDTH (8), .FAIL_CNT_BITS (2)
   ) dut2 (
      .clk (clk), .rst (rst), .start (start2), .wr_en (wr_en2), .rd_en (rd_en2),
      .row_addr (row_addr2), .col_addr (col_addr2), .data_out (data_out2),
      .data_in (data_in2), .busy (busy2), .done (done2), .fail (fail2),
      .fail_valid (fail_valid2), .fail_row (fail_row2), .fail_col (fail_col2),
      .fail_syndrome (fail_syndrome2), .fail_count (fail_count2)
   );

   function automatic logic [7:0] faulty_rd(input logic [7:0] a);
      logic [7:0] v;
      v = mem[a];
      if (saf0_en && a == 8'h32) v[0] = 1'b0;
      if (saf1_en && a[7:4] == 4'd5) v[7] = 1'b1;
      return v;
   endfunction

   // Memory for dut: synchronous write, one-cycle read latency.
   always @(posedge clk) begin
      if (wr_en) begin
         mem[{row_addr, col_addr}] <= data_out;
         if (cpl_en && {row_addr, col_addr} == 8'h23 && data_out == 8'hFF)
            mem[8'h34] <= mem[8'h34] ^ 8'h01;
      end
      if (rd_en) data_in <= faulty_rd({row_addr, col_addr});
   end

   // Memory for dut2: row 5 bit 7 permanently stuck-at-1.
   always @(posedge clk) begin
      if (wr_en2) mem2[{row_addr2, col_addr2}] <= data_out2;
      if (rd_en2) begin
         data_in2 <= mem2[{row_addr2, col_addr2}] |
                     ((row_addr2 == 4'd5) ? 8'h80 : 8'h00);
      end
   end

   // Run monitor for dut, sampled mid-cycle.
   always @(negedge clk) begin
      if (mon_clr) begin
         ops = 0; both_hi = 0; pulses = 0;
         fv_cyc[0] = 0; fv_cyc[1] = 0;
         fv_row = '0; fv_col = '0; fv_syn = '0;
      end else if (mon_en) begin
         if (wr_en || rd_en) ops++;
         if (wr_en && rd_en) both_hi++;
         if (fail_valid) begin
            if (pulses == 0) begin
               fv_row = fail_row; fv_col = fail_col; fv_syn = fail_syndrome;
            end
            if (pulses < 2) fv_cyc[pulses] = cyc;
            pulses++;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse start in cycle 0 and wait (bounded) for done; returns its cycle number.
   task automatic run_test(output int done_at);
      start = 1'b1; mon_clr = 1'b1; mon_en = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; mon_clr = 1'b0; mon_en = 1'b1; cyc = 1;
      while (!done && cyc < 3000) begin
         @(posedge clk); #1; cyc++;
      end
      mon_en  = 1'b0;
      done_at = cyc;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start2 = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("reset_outputs",
            {wr_en, rd_en, row_addr, col_addr, data_out, busy, done, fail, fail_valid,
             fail_row, fail_col, fail_syndrome, fail_count}, 64'd0);
      check("reset_outputs2", {wr_en2, rd_en2, busy2, done2, fail2, fail_count2}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Fault-free run.
      run_test(cyc_done);
      check("ff_done_cycle", cyc_done, 2562);
      check("ff_ops", ops, 2560);
      check("ff_both_strobes", both_hi, 0);
      check("ff_fail", fail, 0);
      check("ff_fail_count", fail_count, 0);
      check("ff_pulses", pulses, 0);
      check("ff_busy_at_done", busy, 0);

      // Bit 0 stuck-at-0 at (3,2); restart directly from DONE.
      saf0_en = 1'b1;
      run_test(cyc_done);
      check("saf0_done_cycle", cyc_done, 2562);
      check("saf0_fail_count", fail_count, 2);
      check("saf0_pulses", pulses, 2);
      check("saf0_m2_cycle", fv_cyc[0], 870);
      check("saf0_m4_cycle", fv_cyc[1], 2204);
      check("saf0_pulse_rc_syn", {fv_row, fv_col, fv_syn}, {4'd3, 4'd2, 8'h01});
      check("saf0_record", {fail, fail_row, fail_col, fail_syndrome}, {1'b1, 4'd3, 4'd2, 8'h01});
      saf0_en = 1'b0;

      // Bit 7 stuck-at-1 across row 5.
      saf1_en = 1'b1;
      run_test(cyc_done);
      check("saf1_done_cycle", cyc_done, 2562);
      check("saf1_fail_count", fail_count, 48);
      check("saf1_pulses", pulses, 48);
      check("saf1_first_cycle", fv_cyc[0], 418);
      check("saf1_record", {fail_row, fail_col, fail_syndrome}, {4'd5, 4'd0, 8'h80});
      saf1_en = 1'b0;

      // Coupling fault: aggressor (2,3), victim (3,4).
      cpl_en = 1'b1;
      run_test(cyc_done);
      check("cpl_done_cycle", cyc_done, 2562);
      check("cpl_done", done, 1);
      check("cpl_fail", fail, 1);
      check("cpl_fail_count", fail_count, 2);
      check("cpl_first_cycle", fv_cyc[0], 362);
      check("cpl_record", {fail_row, fail_col, fail_syndrome}, {4'd3, 4'd4, 8'h01});
      cpl_en = 1'b0;

      // Reset during M3 with a logged failure, then a clean rerun.
      saf1_en = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cyc = 1;
      while (cyc < 1400) begin
         @(posedge clk); #1; cyc++;
      end
      check("mid_fail_before_rst", {busy, fail}, 2'b11);
      rst = 1'b1; #1;
      check("mid_rst_outputs",
            {wr_en, rd_en, row_addr, col_addr, data_out, busy, done, fail, fail_valid,
             fail_row, fail_col, fail_syndrome, fail_count}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; saf1_en = 1'b0;
      @(posedge clk); #1;
      run_test(cyc_done);
      check("rerun_done_cycle", cyc_done, 2562);
      check("rerun_ops", ops, 2560);
      check("rerun_clean", {fail, fail_count, 24'(pulses)}, 33'd0);

      // Narrow counter saturates; start pulsed while busy is ignored.
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0; cyc = 1;
      while (!done2 && cyc < 3000) begin
         start2 = (cyc == 1000);
         @(posedge clk); #1; cyc++;
      end
      start2 = 1'b0;
      check("sat_done_cycle", cyc, 2562);
      check("sat_fail_count", fail_count2, 3);
      check("sat_record", {fail2, fail_row2, fail_col2, fail_syndrome2},
            {1'b1, 4'd5, 4'd0, 8'h80});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
MBIST initiator that drives the MBIST side of the memory/fault-injection path. It runs a March C- sequence over a 2-D (row, col) array, issues one write or read per cycle, compares each read against the expected background, and logs failures. The per-failure strobe and the first-fail record feed the downstream BIRA logic.

Parameters:
ROW_ADDR_BITS, 4, row address width
COL_ADDR_BITS, 4, column address width
DATA_WIDTH, 8, word width; backgrounds are all-0 / all-1
FAIL_CNT_BITS, 8, width of the saturating failure counter

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a test; honoured only in IDLE or DONE
wr_en  out  1  memory write strobe
rd_en  out  1  memory read strobe
row_addr  out  ROW_ADDR_BITS  logical row of current op
col_addr  out  COL_ADDR_BITS  logical column of current op
data_out  out  DATA_WIDTH  write data
data_in  in  DATA_WIDTH  read data, valid exactly 1 cycle after rd_en
busy  out  1  test in progress
done  out  1  test complete; held until the next accepted start or rst
fail  out  1  sticky: any mismatch this run
fail_valid  out  1  one-cycle pulse per mismatch
fail_row  out  ROW_ADDR_BITS  on fail_valid: row of the failing read; after run: first-fail row
fail_col  out  COL_ADDR_BITS  same as fail_row, for the column
fail_syndrome  out  DATA_WIDTH  data_in XOR expected, for the failing or first-fail read
fail_count  out  FAIL_CNT_BITS  mismatches this run, saturating at all-ones

Behaviour:
- Reset: all outputs 0; FSM to IDLE; address counter 0.
- Linear address A = {row, col}; N = 2^(ROW_ADDR_BITS+COL_ADDR_BITS).
  - Up order: 0..N-1.
  - Down order: N-1..0; the counter wraps only at element boundaries.
- March C- elements:
  - M0 up(w0)
  - M1 up(r0,w1)
  - M2 up(r1,w0)
  - M3 down(r0,w1)
  - M4 down(r1,w0)
  - M5 up(r0)
  - Two-op elements: read in one cycle, write to the same address the next cycle.
- FSM states: IDLE -> RUN -> DRAIN -> DONE.
  - IDLE/DONE + start: clear fail, fail_count and first-fail record; drop done; enter RUN.
  - RUN: one op per cycle; exactly one of wr_en/rd_en high; data_out = background (all-0 or all-1) on writes, 0 on reads.
  - RUN -> DRAIN: after the last M5 read (A = N-1).
  - DRAIN: strobes low; compares the final read.
  - DRAIN -> DONE: next cycle; busy = 0, done = 1.
- Timing: start sampled at cycle 0; ops issue on cycles 1..10N; DRAIN at 10N+1; done = 1 from cycle 10N+2.
- Compare pipeline: expected data and address are registered with rd_en. In the following cycle, a mismatch does the following:
  - pulses fail_valid with that address and syndrome;
  - sets fail;
  - increments fail_count, saturating;
  - captures the first-fail record if no earlier mismatch.
- fail_row/col/syndrome outside a fail_valid cycle show the first-fail record.
- start while busy is ignored.
- rst mid-run aborts immediately to reset values; no partial results are retained.
- start on the same cycle done is already high restarts cleanly.

Decomposition:
- Package mbist_pkg:
  - march_elem_e (M0..M5)
  - op_e (OP_RD, OP_WR)
  - fsm_e (IDLE, RUN, DRAIN, DONE)
  - constant table of per-element direction, op count and read/write backgrounds
- Sub-module mbist_addr_gen: up/down linear counter with load-to-0/N-1, increment enable, and last-address flag. The top level splits its count into row/col.

Test Plan:
- Fault-free behavioural memory, 4x4 params, start at cycle 0 -> 2560 ops; done = 1 at cycle 2562; fail = 0; fail_count = 0; fail_valid never pulses.
- Bit 0 stuck-at-0 at (3,2) -> fail_valid pulses in M2 and M4 at row 3, col 2, syndrome 0x01; fail_count = 2; first-fail row/col = 3/2.
- Bit 7 stuck-at-1 on row 5 (all 16 columns) -> mismatches on reads expecting 0 (M1, M3, M5) = 48 fails; first fail (5,0) in M1, syndrome 0x80.
- Coupling model (write w1 to (2,3) flips bit 0 of (3,4)) -> at least one mismatch at row 3, col 4; fail = 1; done still asserted normally.
- rst asserted mid-M3 -> all outputs 0 next cycle; new start -> full fault-free run repeats exactly the same timing.
- FAIL_CNT_BITS = 2 with a full-row SAF -> fail_count saturates at 3; extra start during busy -> no effect on the sequence.
